tick_ratio_meter: RTL

// - Downstream consumer of the dual timer outputs: gate_in <- t1 (1 s window), tick_in <- t2 (~120 Hz pulse).
// - Synchronises and edge-detects both inputs, then counts tick rising edges between consecutive gate rising edges.
// - Publishes each window's count over a valid/ready handshake, with range-check and overflow flags.
// - Used as a self-check of timer calibration and as a rate source for status logic.

---
 rtl/tick_ratio_meter_if.sv | 30 +++
 rtl/tick_ratio_meter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tick_ratio_meter_if.sv
// Result channel of the tick ratio meter: the window count with its flags,
// published under a valid/ready handshake.
interface tick_ratio_meter_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             count_ready;
  logic             in_range;
  logic             overflow;
  logic             dropped;

  modport master (
    output count_out,
    output count_valid,
    input  count_ready,
    output in_range,
    output overflow,
    output dropped
  );

  modport slave (
    input  count_out,
    input  count_valid,
    output count_ready,
    input  in_range,
    input  overflow,
    input  dropped
  );
endinterface

// File: rtl/tick_ratio_meter.sv
// Counts tick rising edges between consecutive gate rising edges and
// publishes each completed window's count with range and overflow flags.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_WAIT_GATE  | no window open yet; ticks ignored, first gate edge opens one
// S_COUNT      | window open; ticks counted, each gate edge closes + reopens
module tick_ratio_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EXPECT_LO   = 119,
  parameter int unsigned EXPECT_HI   = 121
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               gate_in,
  input  logic               tick_in,
  tick_ratio_meter_if.master res
);

  localparam int unsigned      FILL_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_WAIT_GATE = 1'b0,
    S_COUNT     = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_gate_sync;
  logic [SYNC_STAGES-1:0] r_tick_sync;
  logic                   r_gate_prev;
  logic                   r_tick_prev;
  logic                   r_gate_armed;
  logic                   r_tick_armed;
  logic [FILL_W-1:0]      r_fill_cnt;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_win_ovf;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_ovf_nxt;
  logic [CNT_W-1:0]       w_tick_cnt;
  logic                   w_tick_ovf;
  logic                   w_capture;

  logic [CNT_W-1:0]       r_count_out;
  logic                   r_valid;
  logic                   r_in_range;
  logic                   r_overflow;
  logic                   r_dropped;

  logic                   w_gate_synced;
  logic                   w_tick_synced;
  logic                   w_filled;
  logic                   w_gate_stb;
  logic                   w_tick_stb;
  logic [31:0]            w_cnt_ext;
  logic                   w_cap_in_range;
  logic                   w_load;

  assign w_gate_synced = r_gate_sync[SYNC_STAGES-1];
  assign w_tick_synced = r_tick_sync[SYNC_STAGES-1];
  assign w_filled      = (r_fill_cnt == '0);

  // An input already high when reset releases must not look like an edge,
  // so strobes stay disarmed until the flushed chain has shown a low level.
  assign w_gate_stb = w_gate_synced & ~r_gate_prev & r_gate_armed;
  assign w_tick_stb = w_tick_synced & ~r_tick_prev & r_tick_armed;

  // Synchroniser chains, edge registers and the arming logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gate_sync  <= '0;
      r_tick_sync  <= '0;
      r_gate_prev  <= 1'b0;
      r_tick_prev  <= 1'b0;
      r_gate_armed <= 1'b0;
      r_tick_armed <= 1'b0;
      r_fill_cnt   <= FILL_W'(SYNC_STAGES);
    end else begin
      r_gate_sync <= {r_gate_sync[SYNC_STAGES-2:0], gate_in};
      r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], tick_in};
      r_gate_prev <= w_gate_synced;
      r_tick_prev <= w_tick_synced;
      if (!w_filled) begin
        r_fill_cnt <= r_fill_cnt - FILL_W'(1);
      end else begin
        r_gate_armed <= r_gate_armed | ~w_gate_synced;
        r_tick_armed <= r_tick_armed | ~w_tick_synced;
      end
    end
  end

  // FSM state and window counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_WAIT_GATE;
      r_cnt     <= '0;
      r_win_ovf <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_win_ovf <= w_ovf_nxt;
    end
  end

  // Next state, counter update and capture request. A tick coinciding with
  // the closing gate edge belongs to the closing window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_win_ovf;
    w_capture   = 1'b0;
    w_tick_cnt  = r_cnt;
    w_tick_ovf  = r_win_ovf;
    if (w_tick_stb) begin
      if (r_cnt == CNT_MAX) begin
        w_tick_ovf = 1'b1;
      end else begin
        w_tick_cnt = r_cnt + CNT_W'(1);
      end
    end
    case (r_state)
      S_WAIT_GATE: begin
        if (w_gate_stb) begin
          w_state_nxt = S_COUNT;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      S_COUNT: begin
        w_cnt_nxt = w_tick_cnt;
        w_ovf_nxt = w_tick_ovf;
        if (w_gate_stb) begin
          w_capture = 1'b1;
          w_cnt_nxt = '0;
          w_ovf_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_WAIT_GATE;
      end
    endcase
  end

  assign w_cnt_ext      = 32'(w_tick_cnt);
  assign w_cap_in_range = ~w_tick_ovf & (w_cnt_ext >= EXPECT_LO) & (w_cnt_ext <= EXPECT_HI);
  assign w_load         = w_capture & (~r_valid | res.count_ready);

  // Result holding register and handshake; a capture that finds the
  // previous result still unread is discarded and reported on dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count_out <= '0;
      r_valid     <= 1'b0;
      r_in_range  <= 1'b0;
      r_overflow  <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_dropped <= w_capture & r_valid & ~res.count_ready;
      if (w_load) begin
        r_count_out <= w_tick_cnt;
        r_in_range  <= w_cap_in_range;
        r_overflow  <= w_tick_ovf;
        r_valid     <= 1'b1;
      end else if (r_valid && res.count_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign res.count_out   = r_count_out;
  assign res.count_valid = r_valid;
  assign res.in_range    = r_in_range;
  assign res.overflow    = r_overflow;
  assign res.dropped     = r_dropped;

endmodule
